// File: rtl/inst_buffer.sv
// inst_buffer: multi-way circular instruction FIFO between fetch and id_stage.
//
// Each cycle up to WAY_NUM fetched instructions (with their branch-prediction
// packets) are written at the tail. The oldest WAY_NUM entries are shown to
// id_stage in program order. Dispatch consumes 0..WAY_NUM of them.
//
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low reset
//   flush_i               redirect flush; empties the buffer at the next edge
//   inst_buffer_packet_i  WAY_NUM fetch slots; valid bits contiguous from slot 0
//   dispatch_num_i        number of entries consumed this cycle (clamped to occupancy)
//   inst_buffer_packet_o  oldest entries; slot i is the i-th oldest, zero when empty
//   out_valid_o           slot i valid when occupancy > i
//   fetch_stall_o         fetch group refused this cycle; fetch must hold it
//   count_o               current occupancy

package inst_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } IF_ID_PACKET;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } BP_PACKET;

    typedef struct packed {
        IF_ID_PACKET if_id_packet;
        BP_PACKET    bp_packet;
    } INST_BUFFER_PACKET;

endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int WAY_NUM = 3,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush_i,
    input  INST_BUFFER_PACKET [WAY_NUM-1:0]      inst_buffer_packet_i,
    input  logic [$clog2(WAY_NUM+1)-1:0]         dispatch_num_i,
    output INST_BUFFER_PACKET [WAY_NUM-1:0]      inst_buffer_packet_o,
    output logic [WAY_NUM-1:0]                   out_valid_o,
    output logic                                 fetch_stall_o,
    output logic [CNT_W-1:0]                     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IN_W  = $clog2(WAY_NUM + 1);

    // Storage is kept in flops: the read side is combinational and reset has
    // to clear every valid bit asynchronously.
    INST_BUFFER_PACKET mem_reg [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [WAY_NUM-1:0] prefix_valid;
    logic [WAY_NUM-1:0] slot_we;
    logic [PTR_W-1:0]   wr_idx [WAY_NUM];
    logic [PTR_W-1:0]   rd_idx [WAY_NUM];
    logic [IN_W-1:0]    in_num;
    logic [IN_W-1:0]    enq_num;
    logic [CNT_W-1:0]   free_cnt;
    logic [CNT_W-1:0]   deq_num;
    logic               accept;
    logic               enq_go;

    logic               wr_en   [DEPTH];
    INST_BUFFER_PACKET  wr_data [DEPTH];

    // Only the run of valid slots starting at slot 0 counts; anything after
    // the first hole is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < WAY_NUM; gi++) begin : g_slot
            if (gi == 0) begin : g_first
                assign prefix_valid[gi] = inst_buffer_packet_i[gi].if_id_packet.valid;
            end else begin : g_rest
                assign prefix_valid[gi] = prefix_valid[gi-1]
                                        & inst_buffer_packet_i[gi].if_id_packet.valid;
            end
            assign slot_we[gi] = prefix_valid[gi] & enq_go;
            assign wr_idx[gi]  = tail_reg + PTR_W'(gi);
            assign rd_idx[gi]  = head_reg + PTR_W'(gi);

            assign out_valid_o[gi]          = count_reg > CNT_W'(gi);
            assign inst_buffer_packet_o[gi] = out_valid_o[gi] ? mem_reg[rd_idx[gi]] : '0;
        end
    endgenerate

    always_comb begin
        in_num = '0;
        for (int s = 0; s < WAY_NUM; s++) begin
            in_num = in_num + IN_W'(prefix_valid[s]);
        end
    end

    // Acceptance looks only at start-of-cycle free space; a same-cycle
    // dequeue is deliberately not credited, which keeps count <= DEPTH.
    assign free_cnt      = CNT_W'(DEPTH) - count_reg;
    assign accept        = free_cnt >= CNT_W'(in_num);
    assign enq_go        = accept & ~flush_i;
    assign enq_num       = enq_go ? in_num : '0;
    assign fetch_stall_o = ~flush_i & (in_num != '0) & ~accept;

    // Over-requests are clamped to what is actually stored.
    assign deq_num = (CNT_W'(dispatch_num_i) > count_reg) ? count_reg
                                                          : CNT_W'(dispatch_num_i);

    assign head_next  = head_reg + PTR_W'(deq_num);
    assign tail_next  = tail_reg + PTR_W'(enq_num);
    assign count_next = count_reg + CNT_W'(enq_num) - deq_num;
    assign count_o    = count_reg;

    // Steer each fetch slot to its ring position; at most one slot can hit a
    // given entry because WAY_NUM <= DEPTH.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wr_en[e]   = 1'b0;
            wr_data[e] = '0;
        end
        for (int s = 0; s < WAY_NUM; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (slot_we[s] && (wr_idx[s] == PTR_W'(e))) begin
                    wr_en[e]   = 1'b1;
                    wr_data[e] = inst_buffer_packet_i[s];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e] <= '0;
            end
        end else if (flush_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e].if_id_packet.valid <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_en[e]) begin
                    mem_reg[e] <= wr_data[e];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer (WAY_NUM=3, DEPTH=8): a vector table drives each
// cycle; accepted instructions go into a scoreboard queue and are compared
// against the output slots, then popped as they are dispatched.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int WAY   = 3;
    localparam int DEPTH = 8;

    logic                          clock;
    logic                          reset;
    logic                          flush_i;
    INST_BUFFER_PACKET [WAY-1:0]   pkt_i;
    logic [1:0]                    dispatch_num_i;
    INST_BUFFER_PACKET [WAY-1:0]   pkt_o;
    logic [WAY-1:0]                out_valid_o;
    logic                          fetch_stall_o;
    logic [3:0]                    count_o;

    inst_buffer #(.WAY_NUM(WAY), .DEPTH(DEPTH)) dut (
        .clock                (clock),
        .reset                (reset),
        .flush_i              (flush_i),
        .inst_buffer_packet_i (pkt_i),
        .dispatch_num_i       (dispatch_num_i),
        .inst_buffer_packet_o (pkt_o),
        .out_valid_o          (out_valid_o),
        .fetch_stall_o        (fetch_stall_o),
        .count_o              (count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    INST_BUFFER_PACKET sb_q[$];

    typedef struct {
        logic [2:0]  vmask;
        logic [31:0] pc;
        int          disp;
        logic        flush;
        int          exp_count;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic INST_BUFFER_PACKET make_pkt(logic [31:0] pc);
        INST_BUFFER_PACKET p;
        p.if_id_packet.valid = 1'b1;
        p.if_id_packet.inst  = {16'hc0de, pc[15:0]};
        p.if_id_packet.PC    = pc;
        p.if_id_packet.NPC   = pc + 32'd4;
        p.bp_packet.taken    = pc[2];
        p.bp_packet.target   = pc + 32'h100;
        return p;
    endfunction

    task automatic drive(logic [2:0] vmask, logic [31:0] pc, int disp, logic fl);
        for (int i = 0; i < WAY; i++) begin
            pkt_i[i] = vmask[i] ? make_pkt(pc + 32'(4 * i)) : '0;
        end
        dispatch_num_i = 2'(disp);
        flush_i        = fl;
    endtask

    // Called #1 after a rising edge; samples at the falling edge, updates the
    // scoreboard, and returns #1 after the next rising edge.
    task automatic apply(int idx, vec_t v);
        int in_num;
        int deq;
        int start;
        logic [2:0] exp_valid;
        drive(v.vmask, v.pc, v.disp, v.flush);
        if (v.vmask == 3'b101)
            $display("note: row %0d has a hole in the fetch valid mask (protocol violation)", idx);
        @(negedge clock);
        $display("row %0d: vmask=%b pc=%h disp=%0d flush=%b count=%0d stall=%b out_valid=%b",
                 idx, v.vmask, v.pc, v.disp, v.flush, count_o, fetch_stall_o, out_valid_o);
        chk($sformatf("row%0d count", idx), 160'(count_o), 160'(v.exp_count));
        chk($sformatf("row%0d stall", idx), 160'(fetch_stall_o), 160'(v.exp_stall));
        exp_valid = '0;
        for (int i = 0; i < WAY; i++) if (i < sb_q.size()) exp_valid[i] = 1'b1;
        chk($sformatf("row%0d out_valid", idx), 160'(out_valid_o), 160'(exp_valid));
        for (int i = 0; i < WAY; i++) begin
            if (i < sb_q.size())
                chk($sformatf("row%0d slot%0d", idx, i), 160'(pkt_o[i]), 160'(sb_q[i]));
            else
                chk($sformatf("row%0d slot%0d zero", idx, i), 160'(pkt_o[i]), 160'(0));
        end
        if (v.flush) begin
            sb_q.delete();
        end else begin
            in_num = 0;
            for (int i = 0; i < WAY; i++) begin
                if (v.vmask[i] && in_num == i) in_num++;
            end
            start = sb_q.size();
            deq   = (v.disp < start) ? v.disp : start;
            for (int i = 0; i < deq; i++) void'(sb_q.pop_front());
            if ((DEPTH - start) >= in_num) begin
                for (int i = 0; i < in_num; i++) sb_q.push_back(make_pkt(v.pc + 32'(4 * i)));
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 32'h0, 0, 1'b0);

        //           vmask   pc        disp flush cnt stall
        vecs.push_back('{3'b111, 32'h00, 0, 1'b0, 0, 1'b0}); // first group, no bypass
        vecs.push_back('{3'b000, 32'h00, 0, 1'b0, 3, 1'b0}); // PCs 0,4,8 visible
        vecs.push_back('{3'b111, 32'h10, 0, 1'b0, 3, 1'b0});
        vecs.push_back('{3'b111, 32'h20, 0, 1'b0, 6, 1'b1}); // 3 into 2 free: stall
        vecs.push_back('{3'b011, 32'h30, 0, 1'b0, 6, 1'b0}); // 2 into 2 free: full
        vecs.push_back('{3'b001, 32'h40, 0, 1'b0, 8, 1'b1}); // full: stall
        vecs.push_back('{3'b000, 32'h00, 3, 1'b0, 8, 1'b0});
        vecs.push_back('{3'b000, 32'h00, 1, 1'b0, 5, 1'b0});
        vecs.push_back('{3'b111, 32'h50, 2, 1'b0, 4, 1'b0}); // simultaneous enq/deq
        vecs.push_back('{3'b111, 32'h60, 3, 1'b0, 5, 1'b0}); // exactly 3 free
        vecs.push_back('{3'b000, 32'h00, 3, 1'b0, 5, 1'b0});
        vecs.push_back('{3'b000, 32'h00, 1, 1'b0, 2, 1'b0});
        vecs.push_back('{3'b000, 32'h00, 3, 1'b0, 1, 1'b0}); // over-request
        vecs.push_back('{3'b000, 32'h00, 0, 1'b0, 0, 1'b0});
        vecs.push_back('{3'b111, 32'h70, 0, 1'b0, 0, 1'b0}); // head=tail=6: wraps
        vecs.push_back('{3'b000, 32'h00, 3, 1'b0, 3, 1'b0});
        vecs.push_back('{3'b101, 32'h80, 0, 1'b0, 0, 1'b0}); // hole: only slot 0
        vecs.push_back('{3'b000, 32'h00, 0, 1'b0, 1, 1'b0});
        vecs.push_back('{3'b111, 32'h90, 0, 1'b0, 1, 1'b0});
        vecs.push_back('{3'b011, 32'ha0, 0, 1'b0, 4, 1'b0});
        vecs.push_back('{3'b111, 32'hb0, 2, 1'b1, 6, 1'b0}); // flush masks stall
        vecs.push_back('{3'b000, 32'h00, 0, 1'b0, 0, 1'b0});
        vecs.push_back('{3'b111, 32'hb0, 0, 1'b0, 0, 1'b0});

        // Reset state, before any clock edge has been seen.
        #2;
        chk("reset count", 160'(count_o), 160'(0));
        chk("reset out_valid", 160'(out_valid_o), 160'(0));
        chk("reset stall", 160'(fetch_stall_o), 160'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        foreach (vecs[k]) apply(k, vecs[k]);

        // Three entries are now stored. Assert reset mid-cycle during an enqueue.
        drive(3'b111, 32'hc0, 0, 1'b0);
        #1;
        chk("pre-reset count", 160'(count_o), 160'(3));
        reset = 1'b0;
        #1;
        $display("async reset: count=%0d out_valid=%b stall=%b", count_o, out_valid_o, fetch_stall_o);
        chk("async reset count", 160'(count_o), 160'(0));
        chk("async reset out_valid", 160'(out_valid_o), 160'(0));
        chk("async reset stall", 160'(fetch_stall_o), 160'(0));
        chk("async reset slot0", 160'(pkt_o[0]), 160'(0));
        @(posedge clock);
        #1;
        chk("held reset count", 160'(count_o), 160'(0));
        sb_q.delete();
        drive(3'b000, 32'h0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("post reset count", 160'(count_o), 160'(0));
        chk("post reset out_valid", 160'(out_valid_o), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
